// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler feeding an enabled register stage (d_i/en_i).
// Define SERIAL_PARITY_CHECK_EN to require a trailing even-parity bit per word.
module serial_word_assembler #(
  parameter int SIZE      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            bit_valid_i,
  input  logic            bit_i,
  output logic [SIZE-1:0] data_o,
  output logic            load_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int CW = $clog2(SIZE + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_PARITY_CHECK_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [SIZE-1:0] shreg;
  logic [SIZE-1:0] next_word;
  logic            last_bit;

  always_comb begin
    if (MSB_FIRST) next_word = {shreg[SIZE-2:0], bit_i};
    else           next_word = {bit_i, shreg[SIZE-1:1]};
  end

  assign last_bit = (count == CW'(SIZE - 1));
  assign busy_o   = (state != IDLE);

`ifndef SERIAL_PARITY_CHECK_EN
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      count  <= '0;
      shreg  <= '0;
      data_o <= '0;
      load_o <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      err_o  <= 1'b0;
`endif
    end else begin
      load_o <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      err_o  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= SHIFT;
            count <= '0;
            shreg <= '0;
          end
        end
        SHIFT: begin
          // start_i takes priority over a coincident valid bit
          if (start_i) begin
            count <= '0;
            shreg <= '0;
          end else if (bit_valid_i) begin
            shreg <= next_word;
            if (last_bit) begin
              count <= '0;
`ifdef SERIAL_PARITY_CHECK_EN
              state <= PARITY;
`else
              data_o <= next_word;
              load_o <= 1'b1;
              state  <= IDLE;
`endif
            end else begin
              count <= count + 1'b1;
            end
          end
        end
`ifdef SERIAL_PARITY_CHECK_EN
        PARITY: begin
          if (start_i) begin
            state <= SHIFT;
            count <= '0;
            shreg <= '0;
          end else if (bit_valid_i) begin
            if ((^shreg ^ bit_i) == 1'b0) begin
              data_o <= shreg;
              load_o <= 1'b1;
            end else begin
              err_o <= 1'b1;
            end
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
- Upstream feeder for the N-bit enabled register stage: assembles a serial bit stream into a SIZE-bit parallel word.
- Presents the word on data_o and pulses load_o for exactly one cycle. These drive the register's d_i and en_i directly.
- Provides start/restart control, gapped bit input, and a busy flag.

Parameters:
- SIZE, 8, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in data_o[SIZE-1]; 0 = first received bit lands in data_o[0].

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  asynchronous active-high reset.
- start_i  input  1  begin a new word; also restarts a word in progress.
- bit_valid_i  input  1  bit_i is valid this cycle.
- bit_i  input  1  serial data bit.
- data_o  output  SIZE  last completed word; registered.
- load_o  output  1  one-cycle strobe when data_o is updated.
- busy_o  output  1  high while a word is being collected (not IDLE).
- err_o  output  1  one-cycle parity-error strobe; constant 0 without the optional feature.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, bit counter=0, shift register=0, data_o=0, load_o=0, busy_o=0, err_o=0. Holds while rst_i is high; normal operation resumes on the first clk_i edge after release.
- Reset mid-word: the partial word is discarded and data_o returns to 0.
- Bit counter width is $clog2(SIZE+1).
- IDLE:
  - busy_o=0; bit_valid_i is ignored.
  - start_i=1 -> SHIFT; counter and shift register cleared.
- SHIFT:
  - busy_o=1.
  - Each edge with bit_valid_i=1 and start_i=0 shifts bit_i in and increments the counter. MSB_FIRST=1 shifts left, inserting at bit 0; MSB_FIRST=0 shifts right, inserting at bit SIZE-1.
  - bit_valid_i=0 holds state; gaps of any length are allowed.
  - On the edge accepting the SIZE-th bit (counter==SIZE-1), without the optional feature:
    - data_o <= assembled word (including that bit) and load_o <= 1, in the same edge.
    - State -> IDLE.
  - start_i=1 in SHIFT: restart. Counter and shift register are cleared and state stays SHIFT. A bit_valid_i in the same cycle is discarded (start wins), including on what would have been the last bit. data_o is unchanged and load_o is not pulsed.
- Latency: load_o is high in the cycle immediately after the edge that sampled the final bit, for exactly one cycle. data_o is valid in that same cycle and holds until the next load or reset.
- Back-to-back words: start_i may be asserted in the cycle load_o is high. The next word needs a fresh start_i; there is no auto-restart.
- load_o and err_o are never high together. Neither pulses for more than one cycle.

Optional Feature:
- Macro: SERIAL_PARITY_CHECK_EN.
- Defined: adds state PARITY.
  - After the SIZE-th data bit, the FSM goes SHIFT -> PARITY instead of loading; busy_o stays 1.
  - In PARITY, the next bit_valid_i=1 samples the even-parity bit: XOR of the SIZE data bits and bit_i must be 0.
  - Match: data_o <= word and load_o pulses for one cycle -> IDLE.
  - Mismatch: err_o pulses for one cycle, data_o is unchanged, no load_o -> IDLE.
  - start_i in PARITY: restart as in SHIFT.
- Not defined: no PARITY state; err_o is tied to 0; the word loads directly after the SIZE-th bit.

Test Plan:
- SIZE=8, MSB_FIRST=1: reset, start_i, then bits 1,1,0,0,0,0,0,1 on consecutive cycles -> data_o=0xC1, load_o high exactly one cycle after the 8th bit edge, busy_o falls in that same cycle.
- SIZE=8, MSB_FIRST=0: same bit sequence -> data_o=0x83 with a single load_o pulse.
- Gapped input: the same 8 bits with bit_valid_i=0 gaps of 0-3 random cycles -> data_o=0xC1. No load_o before the 8th valid bit.
- Restart: after 5 bits, assert start_i together with bit_valid_i, then send 0xA5 MSB-first -> exactly one load_o, data_o=0xA5.
- Reset mid-word: after 0x3C has loaded, send 4 bits then pulse rst_i between edges -> outputs 0 immediately, state IDLE. The next full word 0x5A then loads correctly.
- With SERIAL_PARITY_CHECK_EN: 0xA5 followed by parity bit 0 -> load_o, data_o=0xA5. Then 0x01 followed by parity bit 0 -> err_o one cycle, no load_o, data_o stays 0xA5.
